// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: after the start-bit detector confirms a start bit,
// times each bit centre, shifts in 8 data bits LSB first, checks parity and stop.
module uart_rx_deser #(
    parameter int BIT_TICKS = 16,
    parameter int PARITY    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       process,
    output logic [7:0] dout,
    output logic       vld_rx,
    output logic       frame_err,
    output logic       parity_err
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        PAR  = 3'd2,
        STOP = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [15:0] LAST_TICK = 16'(BIT_TICKS - 1);
    localparam bit          HAS_PAR   = (PARITY == 32'sd1) || (PARITY == 32'sd2);

    // Unsupported PARITY values fall back to "no parity", so never flag a mismatch.
    function automatic logic parity_mismatch(input logic acc, input logic sample);
        logic mismatch;
        case (PARITY)
            32'sd1:  mismatch = acc ^ sample;
            32'sd2:  mismatch = ~(acc ^ sample);
            default: mismatch = 1'b0;
        endcase
        return mismatch;
    endfunction

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [2:0]  idx_r, idx_s;
    logic [7:0]  shift_r, shift_s;
    logic        acc_r, acc_s;
    logic [7:0]  dout_r, dout_s;
    logic        ferr_r, ferr_s;
    logic        perr_r, perr_s;
    logic        done_r;
    logic        tick_s;

    assign tick_s     = (cnt_r == LAST_TICK);
    assign dout       = dout_r;
    assign frame_err  = ferr_r;
    assign parity_err = perr_r;
    assign vld_rx     = done_r;

    // State and datapath registers; done_r mirrors the DONE state as a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 16'd0;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            acc_r   <= 1'b0;
            dout_r  <= 8'h00;
            ferr_r  <= 1'b0;
            perr_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            acc_r   <= acc_s;
            dout_r  <= dout_s;
            ferr_r  <= ferr_s;
            perr_r  <= perr_s;
            done_r  <= (state_s == DONE);
        end
    end

    // Next-state and datapath logic; rxd is only looked at on bit-centre ticks.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        acc_s   = acc_r;
        dout_s  = dout_r;
        ferr_s  = ferr_r;
        perr_s  = perr_r;
        case (state_r)
            IDLE: begin
                if (process) begin
                    state_s = DATA;
                    cnt_s   = 16'd0;
                    idx_s   = 3'd0;
                    acc_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            DATA: begin
                if (tick_s) begin
                    cnt_s   = 16'd0;
                    shift_s = {rxd, shift_r[7:1]};
                    acc_s   = acc_r ^ rxd;
                    if (idx_r == 3'd7) begin
                        state_s = HAS_PAR ? PAR : STOP;
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            PAR: begin
                if (tick_s) begin
                    cnt_s   = 16'd0;
                    perr_s  = parity_mismatch(acc_r, rxd);
                    state_s = STOP;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            STOP: begin
                if (tick_s) begin
                    cnt_s   = 16'd0;
                    ferr_s  = ~rxd;
                    dout_s  = shift_r;
                    state_s = DONE;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            // One cycle so the detector sees vld_rx before process drops.
            DONE: begin
                cnt_s   = 16'd0;
                state_s = IDLE;
            end
            default: begin
                cnt_s   = 16'd0;
                state_s = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: a behavioural start-bit detector closes the loop,
// frames are scoreboarded as {dout, frame_err, parity_err, latency from E}.
module tb_uart_rx_deser;
    localparam int BT = 16;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       rxd    = 1'b1;
    logic       glitch = 1'b0;
    int         sel    = 0;
    logic [2:0] proc;
    logic [7:0] dout_a [0:2];
    logic       vld_a  [0:2];
    logic       ferr_a [0:2];
    logic       perr_a [0:2];

    logic det_busy = 1'b0;
    logic det_proc = 1'b0;
    logic prev_rxd = 1'b1;
    logic vld_prev = 1'b0;
    int   det_cnt  = 0;
    int   cyc      = 0;
    int   e_cyc    = 0;
    int   long_pulse = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [25:0] exp_q [$];
    logic [25:0] obs_q [$];

    always #5 clk = ~clk;

    assign proc[0] = (sel == 0) ? (det_proc ^ glitch) : 1'b0;
    assign proc[1] = (sel == 1) ? (det_proc ^ glitch) : 1'b0;
    assign proc[2] = (sel == 2) ? (det_proc ^ glitch) : 1'b0;

    uart_rx_deser #(.BIT_TICKS(BT), .PARITY(0)) u_none (
        .clk(clk), .rst(rst), .rxd(rxd), .process(proc[0]),
        .dout(dout_a[0]), .vld_rx(vld_a[0]), .frame_err(ferr_a[0]), .parity_err(perr_a[0]));
    uart_rx_deser #(.BIT_TICKS(BT), .PARITY(1)) u_even (
        .clk(clk), .rst(rst), .rxd(rxd), .process(proc[1]),
        .dout(dout_a[1]), .vld_rx(vld_a[1]), .frame_err(ferr_a[1]), .parity_err(perr_a[1]));
    uart_rx_deser #(.BIT_TICKS(BT), .PARITY(2)) u_odd (
        .clk(clk), .rst(rst), .rxd(rxd), .process(proc[2]),
        .dout(dout_a[2]), .vld_rx(vld_a[2]), .frame_err(ferr_a[2]), .parity_err(perr_a[2]));

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream start-bit detector model: confirm start at its centre, clear on vld_rx.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            det_busy <= 1'b0;
            det_proc <= 1'b0;
            det_cnt  <= 0;
            prev_rxd <= 1'b1;
        end else begin
            prev_rxd <= rxd;
            if (det_proc) begin
                if (vld_a[sel]) begin
                    det_proc <= 1'b0;
                    det_busy <= 1'b0;
                end
            end else if (det_busy) begin
                det_cnt <= det_cnt + 1;
                if (det_cnt == BT / 2 - 1) begin
                    if (rxd == 1'b0) begin
                        det_proc <= 1'b1;
                        e_cyc    <= cyc + 2;
                    end else begin
                        det_busy <= 1'b0;
                    end
                end
            end else if (prev_rxd && !rxd) begin
                det_busy <= 1'b1;
                det_cnt  <= 1;
            end
        end
    end

    // Capture every vld_rx cycle of the selected DUT, with latency from E.
    always @(negedge clk) begin
        vld_prev <= vld_a[sel];
        if (vld_a[sel]) begin
            obs_q.push_back({dout_a[sel], ferr_a[sel], perr_a[sel], 16'(cyc - e_cyc)});
            if (vld_prev) long_pulse <= long_pulse + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rxd = 1'b1;
        end
    endtask

    task automatic send_bit(input logic v);
        for (int i = 0; i < BT; i++) begin
            @(negedge clk);
            rxd = v;
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic has_par, input logic pbit,
                               input logic sbit, input logic exp_perr, input logic push);
        logic [15:0] lat;
        lat = has_par ? 16'd160 : 16'd144;
        if (push) exp_q.push_back({b, ~sbit, exp_perr, lat});
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (has_par) send_bit(pbit);
        send_bit(sbit);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({dout_a[i], vld_a[i], ferr_a[i], perr_a[i]} !== 11'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got %h required 000", i,
                         {dout_a[i], vld_a[i], ferr_a[i], perr_a[i]});
            end
        end
        rst = 1'b0;
        idle(10);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_idle_vld: got %0d pulses required 0", obs_q.size());
        end
    endtask

    task automatic test_good_frame();
        logic [25:0] e, o;
        sel = 0;
        drive_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL good_frame: no vld_rx, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL good_frame: got {dout,ferr,perr,lat}=%h required %h", o, e);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0 || long_pulse != 0) begin
            n_fail++;
            $display("FAIL good_frame_pulse: extra=%0d long=%0d required 0/0", obs_q.size(), long_pulse);
            while (obs_q.size() > 0) void'(obs_q.pop_front());
        end
    endtask

    task automatic test_frame_err();
        logic [25:0] e, o;
        sel = 0;
        drive_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(24);
        drive_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL frame_err: no vld_rx, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL frame_err: got {dout,ferr,perr,lat}=%h required %h", o, e);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0 || long_pulse != 0) begin
            n_fail++;
            $display("FAIL frame_err_pulse: extra=%0d long=%0d required 0/0", obs_q.size(), long_pulse);
            while (obs_q.size() > 0) void'(obs_q.pop_front());
        end
    endtask

    task automatic test_parity();
        logic [25:0] e, o;
        for (int d = 1; d <= 2; d++) begin
            sel = d;
            idle(4);
            drive_frame(8'h07, 1'b1, 1'b1, 1'b1, (d == 2), 1'b1);
            idle(24);
            drive_frame(8'h07, 1'b1, 1'b0, 1'b1, (d == 1), 1'b1);
            idle(8);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL parity dut%0d: no vld_rx, required %h", d, e);
                end else begin
                    o = obs_q.pop_front();
                    if (o !== e) begin
                        n_fail++;
                        $display("FAIL parity dut%0d: got {dout,ferr,perr,lat}=%h required %h", d, o, e);
                    end
                end
            end
            n_checks++;
            if (obs_q.size() != 0 || long_pulse != 0) begin
                n_fail++;
                $display("FAIL parity_pulse dut%0d: extra=%0d long=%0d required 0/0", d, obs_q.size(), long_pulse);
                while (obs_q.size() > 0) void'(obs_q.pop_front());
            end
        end
        sel = 0;
        idle(4);
    endtask

    task automatic test_back_to_back();
        logic [25:0] e, o;
        sel = 0;
        drive_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL back_to_back: no vld_rx, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL back_to_back: got {dout,ferr,perr,lat}=%h required %h", o, e);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0 || long_pulse != 0) begin
            n_fail++;
            $display("FAIL back_to_back_pulse: extra=%0d long=%0d required 0/0", obs_q.size(), long_pulse);
            while (obs_q.size() > 0) void'(obs_q.pop_front());
        end
    endtask

    task automatic test_glitch();
        logic [25:0] e, o;
        int budget = 0;
        sel = 0;
        fork
            drive_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            begin
                while (!(det_proc && cyc >= e_cyc + 2) && budget < 400) begin
                    @(negedge clk);
                    budget++;
                end
                while (det_proc && cyc < e_cyc + 120) begin
                    @(negedge clk);
                    glitch = 1'($urandom_range(0, 1));
                end
                glitch = 1'b0;
            end
        join
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL glitch: no vld_rx, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL glitch: got {dout,ferr,perr,lat}=%h required %h", o, e);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0 || long_pulse != 0) begin
            n_fail++;
            $display("FAIL glitch_pulse: extra=%0d long=%0d required 0/0", obs_q.size(), long_pulse);
            while (obs_q.size() > 0) void'(obs_q.pop_front());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [25:0] e, o;
        int budget = 0;
        sel = 0;
        fork
            drive_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            begin
                while (!(det_proc && cyc >= e_cyc + 70) && budget < 400) begin
                    @(negedge clk);
                    budget++;
                end
                n_checks++;
                if (budget >= 400) begin
                    n_fail++;
                    $display("FAIL rst_mid_wait: no process after %0d cycles, required < 400", budget);
                end
                rst = 1'b1;
                #1;
                n_checks++;
                if ({dout_a[0], vld_a[0], ferr_a[0], perr_a[0]} !== 11'd0) begin
                    n_fail++;
                    $display("FAIL rst_mid_outputs: got %h required 000",
                             {dout_a[0], vld_a[0], ferr_a[0], perr_a[0]});
                end
            end
        join
        idle(4);
        rst = 1'b0;
        idle(20);
        drive_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL rst_mid_frame: no vld_rx, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL rst_mid_frame: got {dout,ferr,perr,lat}=%h required %h", o, e);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0 || long_pulse != 0) begin
            n_fail++;
            $display("FAIL rst_mid_pulse: extra=%0d long=%0d required 0/0", obs_q.size(), long_pulse);
            while (obs_q.size() > 0) void'(obs_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_frame_err();
        test_parity();
        test_back_to_back();
        test_glitch();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
